// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle between the ID decode/compare logic, the IF PC register, the IF/ID
// pipe register and the hazard controller.
//   master : the pipeline side (drives decisions, consumes controls)
//   slave  : the hazard controller (consumes decisions, drives controls)
// Signals
//   id_jump_ctrl/id_jump_value     jump taken in ID and its target PC
//   id_branch_ctrl/id_branch_value branch taken in ID and its target PC
//   id_mem_read, id_dst            ID instruction is a load, and its destination
//   if_src_a, if_src_b             source registers of the IF instruction
//   halt_req, resume               external halt / resume
//   pc_load, next_pc, pc_hold      PC controls
//   ifid_flush, ifid_hold          IF/ID register controls
//   id_bubble                      ID issues a NOP downstream
//   state                          RUN=0, STALL=1, FLUSH=2, HALT=3
// Optional (PIPE_HAZARD_CTRL_STATS_EN): flush_cnt, stall_cnt event counters.
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
  parameter int REG_W = 3
);
  logic             id_jump_ctrl;
  logic [7:0]       id_jump_value;
  logic             id_branch_ctrl;
  logic [7:0]       id_branch_value;
  logic             id_mem_read;
  logic [REG_W-1:0] id_dst;
  logic [REG_W-1:0] if_src_a;
  logic [REG_W-1:0] if_src_b;
  logic             halt_req;
  logic             resume;

  logic             pc_load;
  logic [7:0]       next_pc;
  logic             pc_hold;
  logic             ifid_flush;
  logic             ifid_hold;
  logic             id_bubble;
  logic [1:0]       state;
`ifdef PIPE_HAZARD_CTRL_STATS_EN
  logic [15:0]      flush_cnt;
  logic [15:0]      stall_cnt;
`endif

  modport master (
    output id_jump_ctrl, id_jump_value, id_branch_ctrl, id_branch_value,
    output id_mem_read, id_dst, if_src_a, if_src_b, halt_req, resume,
    input  pc_load, next_pc, pc_hold, ifid_flush, ifid_hold, id_bubble, state
`ifdef PIPE_HAZARD_CTRL_STATS_EN
    , input flush_cnt, stall_cnt
`endif
  );

  modport slave (
    input  id_jump_ctrl, id_jump_value, id_branch_ctrl, id_branch_value,
    input  id_mem_read, id_dst, if_src_a, if_src_b, halt_req, resume,
    output pc_load, next_pc, pc_hold, ifid_flush, ifid_hold, id_bubble, state
`ifdef PIPE_HAZARD_CTRL_STATS_EN
    , output flush_cnt, stall_cnt
`endif
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Sequences the fetch PC and the IF/ID pipe register of the 9-bit-instruction /
// 8-bit-PC core: ID branch/jump decisions become a PC redirect plus IF/ID
// flush, load-use hazards stall fetch, and an external halt/resume freezes it.
// All outputs are registered (one cycle after the sampled event).
// Ports
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : pipe_hazard_ctrl_if.slave (decisions in, PC/IF-ID controls out)
// Parameters
//   REG_W        register-specifier width (must match the interface)
//   FLUSH_CYCLES cycles ifid_flush stays high after a redirect (1..7)
//   STALL_CYCLES cycles fetch is held on a load-use hazard (1..7)
// Optional feature macro: PIPE_HAZARD_CTRL_STATS_EN adds saturating
//   flush_cnt / stall_cnt counters on the interface.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int REG_W        = 3,
  parameter int FLUSH_CYCLES = 1,
  parameter int STALL_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // The counter holds the number of extra cycles still to show after the
  // entry cycle, so it is loaded with CYCLES-1.
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] STALL_INIT = 3'(STALL_CYCLES - 1);

  state_t           state_q;
  logic [2:0]       cnt_q;
  logic             pc_load_q;
  logic [7:0]       next_pc_q;
  logic             pc_hold_q;
  logic             ifid_flush_q;
  logic             ifid_hold_q;
  logic             id_bubble_q;

  logic [REG_W-1:0] dst_s;
  logic [REG_W-1:0] src_a_s;
  logic [REG_W-1:0] src_b_s;
  logic             redirect_s;
  logic             take_redirect_s;
  logic [7:0]       target_s;
  logic             load_use_s;
  logic             take_load_use_s;

  assign dst_s   = bus.id_dst;
  assign src_a_s = bus.if_src_a;
  assign src_b_s = bus.if_src_b;

  // Decode redirect / load-use requests and the states that may accept them.
  always_comb begin
    redirect_s = bus.id_jump_ctrl | bus.id_branch_ctrl;
    if (bus.id_jump_ctrl) begin
      target_s = bus.id_jump_value;     // jump beats branch
    end else begin
      target_s = bus.id_branch_value;
    end
    load_use_s = bus.id_mem_read & ((dst_s == src_a_s) | (dst_s == src_b_s));
    // A redirect is honoured in RUN and also aborts a STALL; FLUSH ignores it
    // because it belongs to an instruction that is being squashed.
    take_redirect_s = redirect_s & ((state_q == ST_RUN) | (state_q == ST_STALL));
    take_load_use_s = (state_q == ST_RUN) & ~redirect_s & load_use_s;
  end

  // Hazard FSM with registered PC / IF-ID controls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RUN;
      cnt_q        <= 3'd0;
      pc_load_q    <= 1'b0;
      next_pc_q    <= 8'h00;
      pc_hold_q    <= 1'b0;
      ifid_flush_q <= 1'b0;
      ifid_hold_q  <= 1'b0;
      id_bubble_q  <= 1'b0;
    end else begin
      // Controls default low every cycle; next_pc keeps its last target.
      pc_load_q    <= 1'b0;
      pc_hold_q    <= 1'b0;
      ifid_flush_q <= 1'b0;
      ifid_hold_q  <= 1'b0;
      id_bubble_q  <= 1'b0;
      if (take_redirect_s) begin
        next_pc_q    <= target_s;
        pc_load_q    <= 1'b1;
        ifid_flush_q <= 1'b1;
        cnt_q        <= FLUSH_INIT;
        state_q      <= ST_FLUSH;
      end else begin
        case (state_q)
          ST_RUN: begin
            if (load_use_s) begin
              pc_hold_q   <= 1'b1;
              ifid_hold_q <= 1'b1;
              id_bubble_q <= 1'b1;
              cnt_q       <= STALL_INIT;
              state_q     <= ST_STALL;
            end else if (bus.halt_req) begin
              pc_hold_q   <= 1'b1;
              ifid_hold_q <= 1'b1;
              state_q     <= ST_HALT;
            end else begin
              state_q     <= ST_RUN;
            end
          end
          ST_STALL: begin
            if (cnt_q != 3'd0) begin
              pc_hold_q   <= 1'b1;
              ifid_hold_q <= 1'b1;
              id_bubble_q <= 1'b1;
              cnt_q       <= cnt_q - 3'd1;
            end else begin
              state_q     <= ST_RUN;
            end
          end
          ST_FLUSH: begin
            if (cnt_q != 3'd0) begin
              ifid_flush_q <= 1'b1;
              cnt_q        <= cnt_q - 3'd1;
            end else begin
              state_q      <= ST_RUN;
            end
          end
          ST_HALT: begin
            // resume wins over a still-asserted halt_req
            if (bus.resume) begin
              state_q     <= ST_RUN;
            end else begin
              pc_hold_q   <= 1'b1;
              ifid_hold_q <= 1'b1;
            end
          end
          default: begin
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
          end
        endcase
      end
    end
  end

  assign bus.pc_load    = pc_load_q;
  assign bus.next_pc    = next_pc_q;
  assign bus.pc_hold    = pc_hold_q;
  assign bus.ifid_flush = ifid_flush_q;
  assign bus.ifid_hold  = ifid_hold_q;
  assign bus.id_bubble  = id_bubble_q;
  assign bus.state      = state_q;

`ifdef PIPE_HAZARD_CTRL_STATS_EN
  logic [15:0] flush_cnt_q;
  logic [15:0] stall_cnt_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  // Saturating redirect / load-use entry counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      flush_cnt_q <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      if (take_redirect_s) begin
        flush_cnt_q <= sat_inc(flush_cnt_q);
      end else begin
        flush_cnt_q <= flush_cnt_q;
      end
      if (take_load_use_s) begin
        stall_cnt_q <= sat_inc(stall_cnt_q);
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
    end
  end

  assign bus.flush_cnt = flush_cnt_q;
  assign bus.stall_cnt = stall_cnt_q;
`else
  logic unused_s;
  assign unused_s = take_load_use_s;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (FLUSH=2/STALL=1 and
// FLUSH=4/STALL=3) share one stimulus stream and are compared every cycle
// against a behavioural model, plus directed literal checks.
module tb_pipe_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       jmp = 1'b0, br = 1'b0, mr = 1'b0, hreq = 1'b0, res = 1'b0;
  logic [7:0] jv = 8'h00, bv = 8'h00;
  logic [2:0] dst = 3'd0, sa = 3'd0, sb = 3'd0;
  logic       check_en = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clock = ~clock;

  pipe_hazard_ctrl_if #(.REG_W(3)) bus_a ();
  pipe_hazard_ctrl_if #(.REG_W(3)) bus_b ();

  assign bus_a.id_jump_ctrl = jmp;    assign bus_b.id_jump_ctrl = jmp;
  assign bus_a.id_jump_value = jv;    assign bus_b.id_jump_value = jv;
  assign bus_a.id_branch_ctrl = br;   assign bus_b.id_branch_ctrl = br;
  assign bus_a.id_branch_value = bv;  assign bus_b.id_branch_value = bv;
  assign bus_a.id_mem_read = mr;      assign bus_b.id_mem_read = mr;
  assign bus_a.id_dst = dst;          assign bus_b.id_dst = dst;
  assign bus_a.if_src_a = sa;         assign bus_b.if_src_a = sa;
  assign bus_a.if_src_b = sb;         assign bus_b.if_src_b = sb;
  assign bus_a.halt_req = hreq;       assign bus_b.halt_req = hreq;
  assign bus_a.resume = res;          assign bus_b.resume = res;

  pipe_hazard_ctrl #(.REG_W(3), .FLUSH_CYCLES(2), .STALL_CYCLES(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(bus_a));
  pipe_hazard_ctrl #(.REG_W(3), .FLUSH_CYCLES(4), .STALL_CYCLES(3)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(bus_b));

  // ---------------- behavioural model ----------------
  // mode: 0 running, 1 stalled, 2 flushing, 3 halted; left = cycles of
  // flush/stall still to be shown including the current one.
  int         flush_len [2] = '{2, 4};
  int         stall_len [2] = '{1, 3};
  int         m_mode [2];
  int         m_left [2];
  logic       e_pl [2], e_ph [2], e_fl [2], e_ih [2], e_bub [2];
  logic [7:0] e_pc [2];
  int         e_fcnt [2], e_scnt [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_left[i] = 0;
      e_pl[i] = 1'b0; e_ph[i] = 1'b0; e_fl[i] = 1'b0; e_ih[i] = 1'b0;
      e_bub[i] = 1'b0; e_pc[i] = 8'h00; e_fcnt[i] = 0; e_scnt[i] = 0;
    end
  endtask

  task automatic model_update();
    logic redirect, lu;
    logic [7:0] tgt;
    if (!reset_n) begin
      model_reset();
      return;
    end
    redirect = jmp | br;
    tgt = jmp ? jv : bv;
    lu = mr && ((dst == sa) || (dst == sb));
    for (int i = 0; i < 2; i++) begin
      e_pl[i] = 1'b0; e_ph[i] = 1'b0; e_fl[i] = 1'b0; e_ih[i] = 1'b0; e_bub[i] = 1'b0;
      if (m_mode[i] == 3) begin
        if (res) m_mode[i] = 0;
        else begin e_ph[i] = 1'b1; e_ih[i] = 1'b1; end
      end else if (m_mode[i] == 2) begin
        m_left[i]--;
        if (m_left[i] > 0) e_fl[i] = 1'b1;
        else m_mode[i] = 0;
      end else if (redirect) begin
        e_pc[i] = tgt; e_pl[i] = 1'b1; e_fl[i] = 1'b1;
        m_mode[i] = 2; m_left[i] = flush_len[i];
        if (e_fcnt[i] < 65535) e_fcnt[i]++;
      end else if (m_mode[i] == 1) begin
        m_left[i]--;
        if (m_left[i] > 0) begin e_ph[i] = 1'b1; e_ih[i] = 1'b1; e_bub[i] = 1'b1; end
        else m_mode[i] = 0;
      end else if (lu) begin
        e_ph[i] = 1'b1; e_ih[i] = 1'b1; e_bub[i] = 1'b1;
        m_mode[i] = 1; m_left[i] = stall_len[i];
        if (e_scnt[i] < 65535) e_scnt[i]++;
      end else if (hreq) begin
        e_ph[i] = 1'b1; e_ih[i] = 1'b1; m_mode[i] = 3;
      end
    end
  endtask

  function automatic logic [14:0] exp_vec(input int i);
    return {e_pl[i], e_pc[i], e_ph[i], e_fl[i], e_ih[i], e_bub[i], 2'(m_mode[i])};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clock) begin
    if (check_en) begin
      chk("cycle_a", {17'd0, bus_a.pc_load, bus_a.next_pc, bus_a.pc_hold, bus_a.ifid_flush,
                      bus_a.ifid_hold, bus_a.id_bubble, bus_a.state}, {17'd0, exp_vec(0)});
      chk("cycle_b", {17'd0, bus_b.pc_load, bus_b.next_pc, bus_b.pc_hold, bus_b.ifid_flush,
                      bus_b.ifid_hold, bus_b.id_bubble, bus_b.state}, {17'd0, exp_vec(1)});
`ifdef PIPE_HAZARD_CTRL_STATS_EN
      chk("stats_a", {bus_a.flush_cnt, bus_a.stall_cnt}, {16'(e_fcnt[0]), 16'(e_scnt[0])});
      chk("stats_b", {bus_b.flush_cnt, bus_b.stall_cnt}, {16'(e_fcnt[1]), 16'(e_scnt[1])});
`endif
    end
  end

  // one clock: model samples the same edge as the DUTs, then step off the edge
  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic idle();
    jmp = 1'b0; br = 1'b0; mr = 1'b0; hreq = 1'b0; res = 1'b0;
    jv = 8'h00; bv = 8'h00; dst = 3'd0; sa = 3'd1; sb = 3'd2;
  endtask

  initial begin
    model_reset();
    idle();
    // reset
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    check_en = 1'b1;
    chk("rst_state", 32'(bus_a.state), 32'd0);
    chk("rst_outs", {27'd0, bus_a.pc_load, bus_a.pc_hold, bus_a.ifid_flush, bus_a.ifid_hold,
                     bus_a.id_bubble}, 32'd0);
    chk("rst_next_pc", 32'(bus_a.next_pc), 32'h00);
    tick();

    // jump to 3C, FLUSH_CYCLES=2 on instance a
    jmp = 1'b1; jv = 8'h3C;
    tick(); idle();
    chk("jmp_pc_load", 32'(bus_a.pc_load), 32'd1);
    chk("jmp_next_pc", 32'(bus_a.next_pc), 32'h3C);
    chk("jmp_flush1", 32'(bus_a.ifid_flush), 32'd1);
    chk("jmp_state", 32'(bus_a.state), 32'd2);
    chk("model_jmp_pc", 32'(e_pc[0]), 32'h3C);
    tick();
    chk("jmp_pulse_end", 32'(bus_a.pc_load), 32'd0);
    chk("jmp_flush2", 32'(bus_a.ifid_flush), 32'd1);
    tick();
    chk("jmp_flush_done", 32'(bus_a.ifid_flush), 32'd0);
    chk("jmp_back_run", 32'(bus_a.state), 32'd0);
    chk("jmp_pc_kept", 32'(bus_a.next_pc), 32'h3C);
    repeat (4) tick();

    // jump beats branch
    jmp = 1'b1; jv = 8'h10; br = 1'b1; bv = 8'h20;
    tick(); idle();
    chk("jb_next_pc", 32'(bus_a.next_pc), 32'h10);
    chk("jb_pc_load", 32'(bus_a.pc_load), 32'd1);
    tick();
    chk("jb_single_pulse", 32'(bus_a.pc_load), 32'd0);
    repeat (4) tick();

    // load-use hit on src_b
    mr = 1'b1; dst = 3'd5; sa = 3'd0; sb = 3'd5;
    tick(); idle();
    chk("lu_holds", {29'd0, bus_a.pc_hold, bus_a.ifid_hold, bus_a.id_bubble}, 32'd7);
    chk("lu_state", 32'(bus_a.state), 32'd1);
    chk("model_lu_hold", 32'(e_ph[0]), 32'd1);
    tick();
    chk("lu_released", 32'(bus_a.pc_hold), 32'd0);
    repeat (3) tick();
    // load-use miss
    mr = 1'b1; dst = 3'd5; sa = 3'd0; sb = 3'd4;
    tick(); idle();
    chk("lu_miss_hold", 32'(bus_a.pc_hold), 32'd0);
    chk("lu_miss_state", 32'(bus_a.state), 32'd0);

    // halt for 4 cycles then resume
    hreq = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("halt_hold", 32'(bus_a.pc_hold), 32'd1);
      chk("halt_state", 32'(bus_a.state), 32'd3);
    end
    hreq = 1'b0; res = 1'b1;
    tick(); idle();
    chk("resume_state", 32'(bus_a.state), 32'd0);
    chk("resume_hold", 32'(bus_a.pc_hold), 32'd0);
    // halt_req and resume together in HALT: resume wins
    hreq = 1'b1;
    tick();
    res = 1'b1;
    tick(); idle();
    chk("resume_wins", 32'(bus_a.state), 32'd0);
    tick();

    // reset one cycle into a 4-cycle flush (instance b)
    jmp = 1'b1; jv = 8'h55;
    tick(); idle();
    tick();
    chk("mid_flush_active", 32'(bus_b.ifid_flush), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_flush", 32'(bus_b.ifid_flush), 32'd0);
    chk("rst_mid_state", 32'(bus_b.state), 32'd0);
`ifdef PIPE_HAZARD_CTRL_STATS_EN
    chk("rst_flush_cnt", 32'(bus_b.flush_cnt), 32'd0);
`endif
    model_reset();
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        reset_n = 1'b0;
        #1 model_reset();
        tick();
        reset_n = 1'b1;
      end
      jmp  = ($urandom_range(0, 9) == 0);
      br   = ($urandom_range(0, 7) == 0);
      jv   = 8'($urandom);
      bv   = 8'($urandom);
      mr   = ($urandom_range(0, 2) == 0);
      dst  = 3'($urandom_range(0, 3));
      sa   = 3'($urandom_range(0, 3));
      sb   = 3'($urandom_range(0, 7));
      hreq = ($urandom_range(0, 14) == 0);
      res  = ($urandom_range(0, 4) == 0);
      tick();
    end
    idle();
    tick();
    check_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
